// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the interval timer controller.
//   - timer_state_t : 2-bit FSM state type with encodings
//                     IDLE=0, ARMED=1, RUN=2, DONE=3
//   - TIMER_STATE_W : width of the exported state encoding
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int TIMER_STATE_W = 2;

    typedef enum logic [TIMER_STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/ctr_core.sv
// -----------------------------------------------------------------------------
// ctr_core
// Up-counter datapath owned by the interval timer controller.
// Ports:
//   i_clk      - system clock, rising edge
//   i_reset_n  - asynchronous active-low reset, clears the count
//   i_clr      - synchronous clear, takes priority over i_en
//   i_en       - increment enable (wraps modulo 2^CNT_WIDTH)
//   o_count    - current counter value
// -----------------------------------------------------------------------------
module ctr_core #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] count_q;

    // Counter register: clear beats increment so the controller can restart
    // the interval on the same edge it would otherwise have counted. The
    // increment wraps naturally at the register width.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else if (i_clr) begin
            count_q <= '0;
        end else if (i_en) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
// Programmable interval timer: sequences a ctr_core counter through
// IDLE -> ARMED -> RUN -> (DONE) and emits a one-cycle tick on each expiry.
// Ports:
//   i_clk, i_reset_n         - clock and asynchronous active-low reset
//   i_cfg_valid/o_cfg_ready  - configuration handshake (ready in IDLE/DONE)
//   i_cfg_period             - interval length in cycles, 0 means 2^CNT_WIDTH
//   i_cfg_periodic           - 1 = auto-reload, 0 = one-shot
//   i_start, i_stop          - command pulses
//   o_count                  - current counter value
//   o_tick                   - one-cycle expiry pulse, aligned with o_count=0
//   o_busy                   - high while in RUN
//   o_state                  - FSM state encoding
// -----------------------------------------------------------------------------
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [CNT_WIDTH-1:0]     i_cfg_period,
    input  logic                     i_cfg_periodic,
    input  logic                     i_start,
    input  logic                     i_stop,
    output logic [CNT_WIDTH-1:0]     o_count,
    output logic                     o_tick,
    output logic                     o_busy,
    output logic [TIMER_STATE_W-1:0] o_state
);

    timer_state_t         state_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 periodic_q;
    logic                 tick_q;
    logic                 busy_q;

    logic                 cfgAccept;
    logic                 atTerminal;
    logic                 ctrClr;
    logic                 ctrEn;
    logic [CNT_WIDTH-1:0] terminalCount;
    logic [CNT_WIDTH-1:0] countVal;

    assign o_cfg_ready = (state_q == IDLE) || (state_q == DONE);
    assign cfgAccept   = i_cfg_valid && o_cfg_ready;

    // A period of 0 stands for 2^CNT_WIDTH; the wrapping subtraction turns it
    // into the all-ones terminal value without a special case.
    assign terminalCount = period_q - CNT_WIDTH'(1);
    assign atTerminal    = (countVal == terminalCount);

    // Counter control: restart the count whenever a new interval begins
    // (config accept, start) or ends (stop, expiry); otherwise count only
    // while running.
    always_comb begin
        ctrClr = 1'b0;
        ctrEn  = 1'b0;
        case (state_q)
            IDLE:  ctrClr = cfgAccept;
            ARMED: ctrClr = i_start;
            RUN: begin
                if (i_stop || atTerminal) begin
                    ctrClr = 1'b1;
                end else begin
                    ctrEn = 1'b1;
                end
            end
            DONE:  ctrClr = cfgAccept || i_start;
            default: begin
                ctrClr = 1'b0;
                ctrEn  = 1'b0;
            end
        endcase
    end

    ctr_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ctr_core (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (ctrClr),
        .i_en      (ctrEn),
        .o_count   (countVal)
    );

    // Sequencing FSM with registered tick and busy. Stop outranks expiry in
    // RUN so a stop on the terminal edge yields no tick. In DONE a config
    // offer outranks start, so a simultaneous start is dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfgAccept) begin
                        period_q   <= i_cfg_period;
                        periodic_q <= i_cfg_periodic;
                        state_q    <= ARMED;
                    end
                end
                ARMED: begin
                    if (i_start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b0;
                    end else if (atTerminal) begin
                        tick_q <= 1'b1;
                        if (!periodic_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (cfgAccept) begin
                        period_q   <= i_cfg_period;
                        periodic_q <= i_cfg_periodic;
                        state_q    <= ARMED;
                    end else if (i_start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = countVal;
    assign o_tick  = tick_q;
    assign o_busy  = busy_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interval_timer_ctrl
// Self-checking bench for interval_timer_ctrl (CNT_WIDTH = 8). Each driven
// cycle pushes its expected outputs into a queue; the entry is popped and
// compared once the DUT has responded to the clock edge.
// -----------------------------------------------------------------------------
module tb_interval_timer_ctrl;

    localparam int W = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct {
        string      tag;
        logic [7:0] count;
        logic       tick;
        logic [1:0] state;
    } expect_t;

    logic         clock;
    logic         resetN;
    logic         cfgValid;
    logic         cfgReady;
    logic [W-1:0] cfgPeriod;
    logic         cfgPeriodic;
    logic         start;
    logic         stop;
    logic [W-1:0] count;
    logic         tick;
    logic         busy;
    logic [1:0]   state;

    expect_t expQ[$];
    int      checks   = 0;
    int      failures = 0;
    int      tickSeen = 0;

    interval_timer_ctrl #(
        .CNT_WIDTH (W)
    ) dut (
        .i_clk          (clock),
        .i_reset_n      (resetN),
        .i_cfg_valid    (cfgValid),
        .o_cfg_ready    (cfgReady),
        .i_cfg_period   (cfgPeriod),
        .i_cfg_periodic (cfgPeriodic),
        .i_start        (start),
        .i_stop         (stop),
        .o_count        (count),
        .o_tick         (tick),
        .o_busy         (busy),
        .o_state        (state)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next
    // rising edge, then pop and compare them on the following falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic pm,
                                 input logic st, input logic sp,
                                 input logic [7:0] eCount, input logic eTick,
                                 input logic [1:0] eState, input string tag);
        expect_t e;
        cfgValid    = v;
        cfgPeriod   = p;
        cfgPeriodic = pm;
        start       = st;
        stop        = sp;
        e.tag   = tag;
        e.count = eCount;
        e.tick  = eTick;
        e.state = eState;
        expQ.push_back(e);
        @(posedge clock);
        @(negedge clock);
        if (tick === 1'b1) tickSeen++;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".count"}, 32'(count), 32'(e.count));
            checkOutput({e.tag, ".tick"},  32'(tick),  32'(e.tick));
            checkOutput({e.tag, ".state"}, 32'(state), 32'(e.state));
            checkOutput({e.tag, ".busy"},  32'(busy),  32'(e.state == S_RUN));
            checkOutput({e.tag, ".ready"}, 32'(cfgReady),
                        32'((e.state == S_IDLE) || (e.state == S_DONE)));
        end
    endtask

    // Let a running timer count for n cycles with the given input levels;
    // expected count is the cycle index modulo the interval length.
    task automatic runFor(input int n, input int modulus, input logic v,
                          input logic [7:0] p, input logic pm, input string tag);
        int k;
        int c;
        for (k = 1; k <= n; k++) begin
            c = k % modulus;
            applyStimulus(v, p, pm, 1'b0, 1'b0, 8'(c), (c == 0), S_RUN, tag);
        end
    endtask

    // Assert reset between edges and confirm the outputs clear immediately.
    task automatic resetDut(input string tag);
        cfgValid = 1'b0; start = 1'b0; stop = 1'b0;
        resetN = 1'b0;
        #1;
        checkOutput({tag, ".count"}, 32'(count), 32'd0);
        checkOutput({tag, ".state"}, 32'(state), 32'(S_IDLE));
        checkOutput({tag, ".tick"},  32'(tick),  32'd0);
        checkOutput({tag, ".busy"},  32'(busy),  32'd0);
        @(negedge clock);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b1; cfgValid = 1'b0; cfgPeriod = '0; cfgPeriodic = 1'b0;
        start = 1'b0; stop = 1'b0;
        #3;
        resetDut("por");

        // Commands in IDLE do nothing.
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_IDLE, "idleStart");
        applyStimulus(0, 8'd0, 0, 0, 1, 8'd0, 0, S_IDLE, "idleStop");

        // One-shot period 3, run twice without reconfiguring.
        applyStimulus(1, 8'd3, 0, 0, 0, 8'd0, 0, S_ARMED, "os.cfg");
        applyStimulus(0, 8'd0, 0, 0, 1, 8'd0, 0, S_ARMED, "os.armedStop");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "os.start");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd1, 0, S_RUN,   "os.c1");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd2, 0, S_RUN,   "os.c2restartIgnored");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 1, S_DONE,  "os.tick");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0, S_DONE,  "os.hold");
        tickSeen = 0;
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "os2.start");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd1, 0, S_RUN,   "os2.c1");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd2, 0, S_RUN,   "os2.c2");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 1, S_DONE,  "os2.tick");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0, S_DONE,  "os2.hold1");
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0, S_DONE,  "os2.hold2");
        checkOutput("os2.tickCount", 32'(tickSeen), 32'd1);

        // Config and start together in DONE: config wins, start dropped.
        applyStimulus(1, 8'd7, 1, 1, 0, 8'd0, 0, S_ARMED, "p7.cfgStart");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "p7.start");
        tickSeen = 0;
        runFor(14, 7, 0, 8'd0, 0, "p7.run");
        checkOutput("p7.tickCount", 32'(tickSeen), 32'd2);
        resetDut("rst1");

        // Stop on the terminal edge; config offer held through RUN/ARMED.
        applyStimulus(1, 8'd4, 1, 0, 0, 8'd0, 0, S_ARMED, "p4.cfg");
        applyStimulus(1, 8'd9, 0, 1, 0, 8'd0, 0, S_RUN,   "p4.start");
        applyStimulus(1, 8'd9, 0, 0, 0, 8'd1, 0, S_RUN,   "p4.c1");
        applyStimulus(1, 8'd9, 0, 0, 0, 8'd2, 0, S_RUN,   "p4.c2");
        applyStimulus(1, 8'd9, 0, 0, 0, 8'd3, 0, S_RUN,   "p4.c3");
        applyStimulus(1, 8'd9, 0, 0, 1, 8'd0, 0, S_ARMED, "p4.stopAtTerm");
        applyStimulus(1, 8'd9, 0, 0, 0, 8'd0, 0, S_ARMED, "p4.offerIgnored");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "p4.restart");
        tickSeen = 0;
        runFor(8, 4, 0, 8'd0, 0, "p4.run");
        checkOutput("p4.tickCount", 32'(tickSeen), 32'd2);
        resetDut("rst2");

        // Period 5 periodic: 4 ticks in 20 cycles.
        applyStimulus(1, 8'd5, 1, 0, 0, 8'd0, 0, S_ARMED, "p5.cfg");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "p5.start");
        tickSeen = 0;
        runFor(20, 5, 0, 8'd0, 0, "p5.run");
        checkOutput("p5.tickCount", 32'(tickSeen), 32'd4);
        applyStimulus(0, 8'd0, 0, 0, 1, 8'd0, 0, S_ARMED, "p5.stop");
        resetDut("rst3");

        // Period 0 means 256 cycles between ticks.
        applyStimulus(1, 8'd0, 1, 0, 0, 8'd0, 0, S_ARMED, "p0.cfg");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "p0.start");
        tickSeen = 0;
        runFor(520, 256, 0, 8'd0, 0, "p0.run");
        checkOutput("p0.tickCount", 32'(tickSeen), 32'd2);
        resetDut("rst4");

        // Period 1: tick every cycle after the first RUN cycle.
        applyStimulus(1, 8'd1, 1, 0, 0, 8'd0, 0, S_ARMED, "p1.cfg");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_RUN,   "p1.start");
        runFor(10, 1, 0, 8'd0, 0, "p1.run");
        resetDut("rst5");

        // Asynchronous reset in the middle of a run at count 37.
        applyStimulus(1, 8'd100, 1, 0, 0, 8'd0, 0, S_ARMED, "p100.cfg");
        applyStimulus(0, 8'd0,   0, 1, 0, 8'd0, 0, S_RUN,   "p100.start");
        runFor(37, 100, 0, 8'd0, 0, "p100.run");
        resetDut("midRunReset");
        applyStimulus(0, 8'd0, 0, 1, 0, 8'd0, 0, S_IDLE, "postReset.start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
